// File: rtl/period_meter_pkg.sv
// Shared types and defaults for the period/high-time meter.
package period_meter_pkg;

  localparam int unsigned PM_CNT_W_DEFAULT = 16;

  typedef enum logic [1:0] {
    PM_IDLE    = 2'd0,
    PM_ARM     = 2'd1,
    PM_MEASURE = 2'd2
  } pm_state_t;

endpackage

// File: rtl/sync_rise_det.sv
// N-stage synchroniser for an asynchronous input plus a one-cycle rising-edge pulse.
module sync_rise_det #(
  parameter int unsigned STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic s,
  output logic rise
);

  logic [STAGES-1:0] sync_q;
  logic              s_d;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_q <= '0;
      s_d    <= 1'b0;
    end else begin
      sync_q <= {sync_q[STAGES-2:0], d};
      s_d    <= sync_q[STAGES-1];
    end
  end

  assign s    = sync_q[STAGES-1];
  assign rise = s & ~s_d;

endmodule

// File: rtl/period_meter.sv
// Measures period and high time of a slow signal in clk cycles; results via valid/ready.
module period_meter
  import period_meter_pkg::*;
#(
  parameter int unsigned CNT_W       = PM_CNT_W_DEFAULT,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             clr,
  input  logic             sig_in,
  input  logic             meas_ready,
  output logic [CNT_W-1:0] period,
  output logic [CNT_W-1:0] high_time,
  output logic             meas_valid,
  output logic             overrun,
  output logic             timeout,
  output logic             busy
);

  localparam logic [CNT_W-1:0] ONE = CNT_W'(1);

  pm_state_t        state;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] hcnt;
  logic             s;
  logic             rise;
  logic             in_meas;
  logic             complete;
  logic             load;
  logic             ovr_set;
  logic             to_set;
  logic             xfer;

  sync_rise_det #(
    .STAGES(SYNC_STAGES)
  ) u_sync (
    .clk (clk),
    .rst (rst),
    .d   (sig_in),
    .s   (s),
    .rise(rise)
  );

  // en=0 outranks a rise, so an aborted measurement never yields a result
  assign in_meas  = (state == PM_MEASURE) && en;
  assign complete = in_meas && rise;
  assign load     = complete && (!meas_valid || meas_ready);
  assign ovr_set  = complete && !load;
  assign to_set   = in_meas && !rise && (cnt == '1);
  assign xfer     = meas_valid && meas_ready;
  assign busy     = (state != PM_IDLE);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= PM_IDLE;
      cnt   <= '0;
      hcnt  <= '0;
    end else begin
      case (state)
        PM_IDLE: begin
          cnt  <= '0;
          hcnt <= '0;
          if (en) state <= PM_ARM;
        end
        PM_ARM: begin
          if (!en) begin
            state <= PM_IDLE;
          end else if (rise) begin
            cnt   <= ONE;
            hcnt  <= ONE;
            state <= PM_MEASURE;
          end
        end
        PM_MEASURE: begin
          if (!en) begin
            state <= PM_IDLE;
          end else if (rise) begin
            cnt  <= ONE;
            hcnt <= ONE;
          end else if (cnt == '1) begin
            state <= PM_ARM;
          end else begin
            cnt <= cnt + ONE;
            if (s) hcnt <= hcnt + ONE;
          end
        end
        default: state <= PM_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      period     <= '0;
      high_time  <= '0;
      meas_valid <= 1'b0;
    end else if (load) begin
      period     <= cnt;
      high_time  <= hcnt;
      meas_valid <= 1'b1;
    end else if (xfer) begin
      meas_valid <= 1'b0;
    end
  end

  // Setting a flag takes precedence over a simultaneous clr
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      overrun <= 1'b0;
      timeout <= 1'b0;
    end else begin
      overrun <= ovr_set | (overrun & ~clr);
      timeout <= to_set  | (timeout & ~clr);
    end
  end

endmodule

// File: tb/tb_period_meter.sv
// Directed self-checking bench for period_meter (16-bit and 4-bit instances).
module tb_period_meter;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        clr = 1'b0;

  logic        en = 1'b0, sig_a = 1'b0, meas_ready = 1'b0;
  logic [15:0] period, high_time;
  logic        meas_valid, overrun, timeout, busy;

  logic        en_b = 1'b0, sig_b = 1'b0, ready_b = 1'b0;
  logic [3:0]  period_b, high_b;
  logic        valid_b, overrun_b, timeout_b, busy_b;

  int n_checks = 0;
  int n_fail   = 0;
  int res_cnt  = 0;
  logic [15:0] last_p, last_h;

  always #5 clk = ~clk;

  period_meter #(.CNT_W(16), .SYNC_STAGES(2)) u_dut (
    .clk(clk), .rst(rst), .en(en), .clr(clr), .sig_in(sig_a),
    .meas_ready(meas_ready), .period(period), .high_time(high_time),
    .meas_valid(meas_valid), .overrun(overrun), .timeout(timeout), .busy(busy)
  );

  period_meter #(.CNT_W(4), .SYNC_STAGES(2)) u_small (
    .clk(clk), .rst(rst), .en(en_b), .clr(clr), .sig_in(sig_b),
    .meas_ready(ready_b), .period(period_b), .high_time(high_b),
    .meas_valid(valid_b), .overrun(overrun_b), .timeout(timeout_b), .busy(busy_b)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Drive sig_a for one cycle and record any result presented afterwards
  task automatic step(input logic v);
    sig_a = v;
    tick();
    if (meas_valid) begin
      res_cnt++;
      last_p = period;
      last_h = high_time;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    #2;
    n_checks++;
    if ({meas_valid, overrun, timeout, busy} !== 4'b0000) begin
      n_fail++; $display("FAIL reset_flags: got %b expected 0000", {meas_valid, overrun, timeout, busy});
    end
    n_checks++;
    if ({period, high_time} !== 32'd0) begin
      n_fail++; $display("FAIL reset_result: got %0d/%0d expected 0/0", period, high_time);
    end
    n_checks++;
    if ({valid_b, timeout_b, busy_b, period_b} !== 7'd0) begin
      n_fail++; $display("FAIL reset_small: got %b expected 0", {valid_b, timeout_b, busy_b, period_b});
    end
    tick();
    tick();
    rst = 1'b0;
    tick();
    n_checks++;
    if (busy !== 1'b0) begin
      n_fail++; $display("FAIL idle_busy: got %b expected 0", busy);
    end
  endtask

  task automatic test_timeout();
    en_b = 1'b1;
    ready_b = 1'b0;
    tick();
    sig_b = 1'b1;
    for (int i = 0; i < 17; i++) tick();
    n_checks++;
    if (timeout_b !== 1'b0) begin
      n_fail++; $display("FAIL timeout_early: got %b expected 0", timeout_b);
    end
    tick();
    n_checks++;
    if ({timeout_b, busy_b, valid_b} !== 3'b110) begin
      n_fail++; $display("FAIL timeout_set: got to/busy/valid=%b expected 110", {timeout_b, busy_b, valid_b});
    end
    clr = 1'b1;
    tick();
    clr = 1'b0;
    n_checks++;
    if (timeout_b !== 1'b0) begin
      n_fail++; $display("FAIL timeout_clr: got %b expected 0", timeout_b);
    end
    sig_b = 1'b0;
    for (int i = 0; i < 3; i++) tick();
    for (int p = 0; p < 2; p++) begin
      for (int i = 0; i < 6; i++) begin
        sig_b = (i < 3);
        tick();
      end
    end
    n_checks++;
    if ({valid_b, period_b, high_b} !== {1'b1, 4'd6, 4'd3}) begin
      n_fail++; $display("FAIL timeout_next: got v=%b p=%0d h=%0d expected v=1 p=6 h=3", valid_b, period_b, high_b);
    end
    en_b = 1'b0;
  endtask

  task automatic test_divider_period();
    en = 1'b1;
    meas_ready = 1'b1;
    res_cnt = 0;
    for (int p = 0; p < 6; p++) begin
      for (int i = 0; i < 16; i++) begin
        step(i < 8);
        if (meas_valid) begin
          n_checks++;
          if (period !== 16'd16 || high_time !== 16'd8) begin
            n_fail++; $display("FAIL div_result: got p=%0d h=%0d expected p=16 h=8", period, high_time);
          end
        end
      end
    end
    n_checks++;
    if (res_cnt != 5) begin
      n_fail++; $display("FAIL div_count: got %0d results expected 5", res_cnt);
    end
    n_checks++;
    if ({overrun, timeout} !== 2'b00) begin
      n_fail++; $display("FAIL div_flags: got %b expected 00", {overrun, timeout});
    end
  endtask

  task automatic test_overrun();
    logic        seen;
    logic        first_ovr;
    logic [15:0] first_p;
    seen = 1'b0;
    first_ovr = 1'b1;
    first_p = '0;
    en = 1'b0;
    step(0); step(0);
    meas_ready = 1'b0;
    en = 1'b1;
    step(0);
    for (int p = 0; p < 4; p++) begin
      for (int i = 0; i < 8; i++) begin
        step(i < 3);
        if (meas_valid && !seen) begin
          seen = 1'b1;
          first_ovr = overrun;
          first_p = period;
        end
      end
    end
    n_checks++;
    if (first_p !== 16'd8 || first_ovr !== 1'b0) begin
      n_fail++; $display("FAIL ovr_first: got p=%0d ovr=%b expected p=8 ovr=0", first_p, first_ovr);
    end
    n_checks++;
    if ({meas_valid, overrun, period, high_time} !== {1'b1, 1'b1, 16'd8, 16'd3}) begin
      n_fail++; $display("FAIL ovr_held: got v=%b o=%b p=%0d h=%0d expected v=1 o=1 p=8 h=3",
                         meas_valid, overrun, period, high_time);
    end
    clr = 1'b1;
    step(0);
    clr = 1'b0;
    n_checks++;
    if ({overrun, meas_valid} !== 2'b01) begin
      n_fail++; $display("FAIL ovr_clr: got o/v=%b expected 01", {overrun, meas_valid});
    end
    meas_ready = 1'b1;
    step(0);
    n_checks++;
    if (meas_valid !== 1'b0) begin
      n_fail++; $display("FAIL ovr_accept: got %b expected 0", meas_valid);
    end
  endtask

  task automatic test_min_period();
    en = 1'b0;
    step(0); step(0);
    en = 1'b1;
    meas_ready = 1'b1;
    step(0);
    res_cnt = 0;
    for (int i = 0; i < 20; i++) begin
      step(i < 16 ? logic'(i % 2 == 0) : 1'b0);
      if (meas_valid) begin
        n_checks++;
        if (period !== 16'd2 || high_time !== 16'd1) begin
          n_fail++; $display("FAIL min_result: got p=%0d h=%0d expected p=2 h=1", period, high_time);
        end
      end
    end
    n_checks++;
    if (res_cnt != 7) begin
      n_fail++; $display("FAIL min_count: got %0d results expected 7", res_cnt);
    end
    n_checks++;
    if (overrun !== 1'b0) begin
      n_fail++; $display("FAIL min_overrun: got %b expected 0", overrun);
    end
  endtask

  task automatic test_back_to_back();
    en = 1'b0;
    step(0); step(0);
    meas_ready = 1'b0;
    en = 1'b1;
    step(0);
    step(1); step(1);
    for (int i = 0; i < 4; i++) step(0);
    step(1); step(1);
    for (int i = 0; i < 7; i++) step(0);
    step(1); step(1);
    n_checks++;
    if ({meas_valid, period, high_time} !== {1'b1, 16'd6, 16'd2}) begin
      n_fail++; $display("FAIL b2b_pending: got v=%b p=%0d h=%0d expected v=1 p=6 h=2", meas_valid, period, high_time);
    end
    // Accept in the same cycle the next result completes
    meas_ready = 1'b1;
    step(1);
    n_checks++;
    if ({meas_valid, overrun, period, high_time} !== {1'b1, 1'b0, 16'd9, 16'd2}) begin
      n_fail++; $display("FAIL b2b_swap: got v=%b o=%b p=%0d h=%0d expected v=1 o=0 p=9 h=2",
                         meas_valid, overrun, period, high_time);
    end
    step(0);
    n_checks++;
    if (meas_valid !== 1'b0) begin
      n_fail++; $display("FAIL b2b_drain: got %b expected 0", meas_valid);
    end
  endtask

  task automatic test_abort();
    en = 1'b0;
    step(0); step(0);
    meas_ready = 1'b1;
    en = 1'b1;
    step(0);
    res_cnt = 0;
    last_p = '0;
    last_h = '0;
    for (int i = 0; i < 4; i++) step(1);
    step(0); step(0);
    en = 1'b0;
    step(0); step(0);
    en = 1'b1;
    for (int p = 0; p < 2; p++) begin
      for (int i = 0; i < 8; i++) step(i < 4);
    end
    n_checks++;
    if (res_cnt != 1) begin
      n_fail++; $display("FAIL abort_count: got %0d results expected 1", res_cnt);
    end
    n_checks++;
    if (last_p !== 16'd8 || last_h !== 16'd4) begin
      n_fail++; $display("FAIL abort_result: got p=%0d h=%0d expected p=8 h=4", last_p, last_h);
    end
  endtask

  task automatic test_async_reset();
    en = 1'b0;
    step(0); step(0);
    meas_ready = 1'b0;
    en = 1'b1;
    step(0);
    for (int p = 0; p < 2; p++) begin
      for (int i = 0; i < 8; i++) step(i < 4);
    end
    step(1); step(1);
    n_checks++;
    if ({meas_valid, busy} !== 2'b11) begin
      n_fail++; $display("FAIL arst_pre: got v/busy=%b expected 11", {meas_valid, busy});
    end
    #3;
    rst = 1'b1;
    #1;
    n_checks++;
    if ({meas_valid, overrun, timeout, busy, period, high_time} !== 36'd0) begin
      n_fail++; $display("FAIL arst_outputs: got v=%b o=%b t=%b b=%b p=%0d h=%0d expected all 0",
                         meas_valid, overrun, timeout, busy, period, high_time);
    end
    n_checks++;
    if ({valid_b, timeout_b, busy_b} !== 3'b000) begin
      n_fail++; $display("FAIL arst_small: got %b expected 000", {valid_b, timeout_b, busy_b});
    end
    tick();
    rst = 1'b0;
    en = 1'b0;
    tick();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail + 1);
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_timeout();
    test_divider_period();
    test_overrun();
    test_min_period();
    test_back_to_back();
    test_abort();
    test_async_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/period_meter.md
Name: period_meter

Overview:
- Measures the period and high time of a slow digital signal, in cycles of the system clock.
- Typical source is the toggling `out` of the frequency divider or one of its `div_*` taps.
- Sits directly downstream of the divider as its self-check and monitoring stage.
- Results go out through a valid/ready register interface to a status/CSR consumer.

Parameters:
- CNT_W, 16: width of the period and high-time counters and result fields.
- SYNC_STAGES, 2: synchroniser flops on sig_in. Legal values are 2 or 3.

Ports:
- clk, input, 1: system clock. Everything is on the rising edge.
- rst, input, 1: asynchronous, active-high reset.
- en, input, 1: measurement enable. Deassertion aborts the measurement in progress.
- clr, input, 1: synchronous single-cycle clear of the sticky flags `overrun` and `timeout`.
- sig_in, input, 1: signal under measurement. It is asynchronous to clk.
- meas_ready, input, 1: consumer accepts the result.
- period, output, CNT_W: clk cycles between two consecutive detected rising edges of sig_in.
- high_time, output, CNT_W: clk cycles that sig_in was high within that period.
- meas_valid, output, 1: result is valid and held until accepted.
- overrun, output, 1: sticky. A new result completed while the previous one was still unaccepted.
- timeout, output, 1: sticky. The period counter saturated with no rising edge.
- busy, output, 1: FSM is in ARM or MEASURE.

Behaviour:

Reset (async, rst=1):
- All outputs are 0.
- FSM is in IDLE.
- Synchroniser flops and counters are 0.

Input conditioning:
- sig_in passes through SYNC_STAGES flops to give `s`.
- `rise` = s & ~s_d, where s_d is s delayed by one cycle.
- With SYNC_STAGES=2, `rise` is true in the 2nd cycle after sig_in is first sampled high.
- Minimum measurable high or low time is 1 clk cycle, so the minimum period is 2.

FSM:
- IDLE
  - Counters are held at 0.
  - When en=1, go to ARM.
- ARM
  - Wait for `rise`.
  - On `rise`: cnt<=1, hcnt<=1, go to MEASURE.
  - When en=0, go to IDLE.
- MEASURE, one action per cycle, in priority order:
  1. en=0: go to IDLE. The partial count is discarded and no result is produced.
  2. `rise`: the result is complete (see "Result completion" below). Then cnt<=1, hcnt<=1, stay in MEASURE.
  3. cnt equals all-ones: set timeout, go to ARM, no result.
  4. Otherwise: cnt<=cnt+1, and hcnt<=hcnt+1 if s=1.

Result completion:
- If meas_valid=0 or meas_ready=1 in that cycle: load period<=cnt and high_time<=hcnt, and set meas_valid<=1 on the next edge.
- Otherwise: keep the old result and set overrun.

Handshake:
- meas_valid is high and the result is stable until a cycle with meas_valid & meas_ready; meas_valid clears after that cycle.
- If the transfer and a new completion happen in the same cycle, the new result is loaded and meas_valid stays 1. This is not an overrun.

Other rules:
- Latency: meas_valid rises 3 clk edges after sig_in is first sampled high, with SYNC_STAGES=2.
- clr clears both sticky flags. If a flag is set in the same cycle as clr, set wins.
- en=0 does not clear a pending meas_valid or the flags.
- hcnt never exceeds cnt. There is no arithmetic wrap, because cnt saturates into timeout.

Decomposition:
- Package `period_meter_pkg` holds:
  - the state enum `pm_state_t` {PM_IDLE, PM_ARM, PM_MEASURE};
  - the default CNT_W.
- One sub-module, `sync_rise_det`: an N-stage synchroniser plus the rising-edge pulse, output s and rise. It is reusable by other blocks.

Test Plan:
1. Reset, en=1, meas_ready=1, sig_in toggling every 8 clk cycles (the divider `out` pattern) -> from the second rise on, every result is period=16, high_time=8; overrun=0, timeout=0.
2. sig_in 3 cycles high / 5 low, meas_ready=0 for 2 periods -> first result period=8, high_time=3 is held; overrun=1 at the second completion. Pulse clr -> overrun=0.
3. CNT_W=4, sig_in stuck high after one rise -> timeout=1 after 15 cycles in MEASURE, FSM returns to ARM, meas_valid stays 0. The next two rises 6 cycles apart -> period=6.
4. sig_in toggling every cycle (period 2) -> period=2 and high_time=1 on every result.
5. Deassert en mid-MEASURE, then reassert -> no result from the partial period; the first result after reassert needs two fresh rises.
6. Assert rst mid-MEASURE with meas_valid=1 -> all outputs are 0 immediately, without waiting for a clock edge; busy=0.
